// File: rtl/cmp_share_arbiter.sv
// rtl/cmp_share_arbiter.sv - round-robin sharing of one external signed comparator
// Grants one requester per operation and returns the registered comparator result with its id.
module cmp_share_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int WIDTH   = 16,
   parameter int ID_W    = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req,
   input  logic [NUM_REQ*WIDTH-1:0] a_flat,
   input  logic [NUM_REQ*WIDTH-1:0] b_flat,
   output logic [NUM_REQ-1:0]       gnt,
   output logic [WIDTH-1:0]         cmp_a,
   output logic [WIDTH-1:0]         cmp_b,
   input  logic                     cmp_gt,
   input  logic                     cmp_lt,
   input  logic                     cmp_eq,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [ID_W-1:0]          rsp_id,
   output logic                     rsp_gt,
   output logic                     rsp_lt,
   output logic                     rsp_eq,
   output logic                     rsp_err,
   output logic                     busy
);

   typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;

   state_t            state_q, state_d;
   logic [ID_W-1:0]   rr_ptr_q;
   logic [WIDTH-1:0]  cmp_a_q, cmp_b_q;
   logic              rsp_valid_q;
   logic [ID_W-1:0]   rsp_id_q;
   logic              rsp_gt_q, rsp_lt_q, rsp_eq_q, rsp_err_q;

   logic              hi_vld, lo_vld, pick_vld;
   logic [ID_W-1:0]   hi_idx, lo_idx, pick_idx, pick_next;
   logic [WIDTH-1:0]  pick_a, pick_b;
   logic              one_hot;

   // Two priority scans: requesters at/after the pointer first, then wrap to the lowest index.
   always_comb begin
      hi_vld = 1'b0;
      lo_vld = 1'b0;
      hi_idx = '0;
      lo_idx = '0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
         if (req[i]) begin
            lo_vld = 1'b1;
            lo_idx = ID_W'(i);
            if (ID_W'(i) >= rr_ptr_q) begin
               hi_vld = 1'b1;
               hi_idx = ID_W'(i);
            end
         end
      end
      pick_vld  = hi_vld | lo_vld;
      pick_idx  = hi_vld ? hi_idx : lo_idx;
      pick_next = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
      pick_a    = '0;
      pick_b    = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == pick_idx) begin
            pick_a = a_flat[i*WIDTH +: WIDTH];
            pick_b = b_flat[i*WIDTH +: WIDTH];
         end
      end
   end

   assign one_hot = ( cmp_gt & ~cmp_lt & ~cmp_eq) |
                    (~cmp_gt &  cmp_lt & ~cmp_eq) |
                    (~cmp_gt & ~cmp_lt &  cmp_eq);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (pick_vld) state_d = S_CMP;
         S_CMP:   state_d = S_RESP;
         S_RESP:  if (rsp_ready) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Grant is combinational in the IDLE cycle; masked while reset is asserted.
   always_comb begin
      gnt = '0;
      if (rst_n && state_q == S_IDLE && pick_vld) gnt[pick_idx] = 1'b1;
      busy = (state_q != S_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_q    <= '0;
         cmp_a_q     <= '0;
         cmp_b_q     <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_gt_q    <= 1'b0;
         rsp_lt_q    <= 1'b0;
         rsp_eq_q    <= 1'b0;
         rsp_err_q   <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (pick_vld) begin
                  cmp_a_q  <= pick_a;
                  cmp_b_q  <= pick_b;
                  rsp_id_q <= pick_idx;
                  rr_ptr_q <= pick_next;
               end
            end
            S_CMP: begin
               rsp_gt_q    <= cmp_gt & one_hot;
               rsp_lt_q    <= cmp_lt & one_hot;
               rsp_eq_q    <= cmp_eq & one_hot;
               rsp_err_q   <= ~one_hot;
               rsp_valid_q <= 1'b1;
            end
            S_RESP: if (rsp_ready) rsp_valid_q <= 1'b0;
            default: ;
         endcase
      end
   end

   assign cmp_a     = cmp_a_q;
   assign cmp_b     = cmp_b_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_gt    = rsp_gt_q;
   assign rsp_lt    = rsp_lt_q;
   assign rsp_eq    = rsp_eq_q;
   assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// tb/tb_cmp_share_arbiter.sv - self-checking bench for cmp_share_arbiter
// Transaction-level model checked every negedge, plus directed literal expectations.
module tb_cmp_share_arbiter;
   localparam int N  = 4;
   localparam int W  = 16;
   localparam int IW = 2;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [N-1:0]    req;
   logic [N*W-1:0]  a_flat, b_flat;
   logic [N-1:0]    gnt;
   logic [W-1:0]    cmp_a, cmp_b;
   logic            cmp_gt, cmp_lt, cmp_eq;
   logic            rsp_valid, rsp_ready;
   logic [IW-1:0]   rsp_id;
   logic            rsp_gt, rsp_lt, rsp_eq, rsp_err, busy;
   logic            force_gt, force_lt, force_eq;

   int total = 0;
   int bad   = 0;

   cmp_share_arbiter #(.NUM_REQ(N), .WIDTH(W), .ID_W(IW)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .a_flat(a_flat), .b_flat(b_flat),
      .gnt(gnt), .cmp_a(cmp_a), .cmp_b(cmp_b),
      .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_err(rsp_err),
      .busy(busy)
   );

   // External comparator with fault-injection overrides.
   assign cmp_gt = force_gt | ($signed(cmp_a) >  $signed(cmp_b));
   assign cmp_lt = force_lt | ($signed(cmp_a) <  $signed(cmp_b));
   assign cmp_eq = force_eq | (cmp_a == cmp_b);

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 = free, 1 = operands at comparator, 2 = answer pending.
   int          m_phase, m_ptr, m_id;
   logic [W-1:0] m_a, m_b;
   logic        m_gt, m_lt, m_eq, m_err;

   always @(negedge clk) begin
      int k, j, ones;
      logic [N-1:0] eg;
      logic g, l, e;
      if (!rst_n) begin
         m_phase = 0; m_ptr = 0; m_id = 0; m_a = '0; m_b = '0;
         m_gt = 0; m_lt = 0; m_eq = 0; m_err = 0;
         chk("rst_gnt", gnt, 0);
         chk("rst_busy", busy, 0);
         chk("rst_cmp_a", cmp_a, 0);
         chk("rst_cmp_b", cmp_b, 0);
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp", {rsp_id, rsp_gt, rsp_lt, rsp_eq, rsp_err}, 0);
      end else begin
         k = -1;
         for (int i = 0; i < N; i++) begin
            j = (m_ptr + i) % N;
            if (k < 0 && req[j]) k = j;
         end
         eg = '0;
         if (m_phase == 0 && k >= 0) eg[k] = 1'b1;
         chk("m_gnt", gnt, eg);
         chk("m_busy", busy, m_phase != 0);
         chk("m_cmp_a", cmp_a, m_a);
         chk("m_cmp_b", cmp_b, m_b);
         chk("m_rsp_valid", rsp_valid, m_phase == 2);
         chk("m_rsp_id", rsp_id, m_id);
         chk("m_rsp_flags", {rsp_gt, rsp_lt, rsp_eq, rsp_err}, {m_gt, m_lt, m_eq, m_err});
         case (m_phase)
            0: if (k >= 0) begin
               m_a = a_flat[k*W +: W];
               m_b = b_flat[k*W +: W];
               m_id = k;
               m_ptr = (k + 1) % N;
               m_phase = 1;
            end
            1: begin
               g = force_gt | ($signed(m_a) > $signed(m_b));
               l = force_lt | ($signed(m_a) < $signed(m_b));
               e = force_eq | (m_a == m_b);
               ones = int'(g) + int'(l) + int'(e);
               m_err = (ones != 1);
               m_gt = g & !m_err;
               m_lt = l & !m_err;
               m_eq = e & !m_err;
               m_phase = 2;
            end
            default: if (rsp_ready) m_phase = 0;
         endcase
      end
   end

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
      a_flat[i*W +: W] = a;
      b_flat[i*W +: W] = b;
   endtask

   // Single operation with rsp_ready high; requester drops req after its grant.
   task automatic run_op(input logic [N-1:0] mask, input int eid,
                         input logic egt, input logic elt, input logic eeq, input logic eerr);
      int n;
      req = mask;
      #1;
      n = 0;
      while (gnt == 0 && n < 10) begin
         step(1);
         n++;
      end
      chk("op_gnt", gnt, 32'(1) << eid);
      step(1);
      req = '0;
      n = 1;
      while (!rsp_valid && n < 10) begin
         step(1);
         n++;
      end
      chk("op_latency", n, 2);
      chk("op_rsp_valid", rsp_valid, 1);
      chk("op_rsp_id", rsp_id, eid);
      chk("op_rsp_flags", {rsp_gt, rsp_lt, rsp_eq, rsp_err}, {egt, elt, eeq, eerr});
      step(1);
   endtask

   int gcyc[16], gid[16], rcyc[16], rid[16];
   int ng, nr;
   int exp_c[5] = '{0, 3, 6, 9, 12};
   int exp_id[5] = '{0, 1, 2, 3, 0};

   initial begin
      rst_n = 1'b0;
      req = 4'b0001;
      a_flat = '0;
      b_flat = '0;
      rsp_ready = 1'b1;
      force_gt = 0; force_lt = 0; force_eq = 0;
      set_op(0, 16'h0005, 16'hFFFE);
      step(2);
      chk("reset_gnt_masked", gnt, 0);
      chk("reset_busy", busy, 0);
      chk("reset_rsp_valid", rsp_valid, 0);

      // T1: 5 > -2
      rst_n = 1'b1;
      run_op(4'b0001, 0, 1, 0, 0, 0);

      // T2: all requesting, rotation from a fresh pointer
      rst_n = 1'b0;
      step(1);
      rst_n = 1'b1;
      for (int i = 0; i < N; i++) set_op(i, 16'(i * 100), 16'd200);
      req = 4'b1111;
      ng = 0;
      nr = 0;
      for (int c = 0; c < 15; c++) begin
         #1;
         if (gnt != 0 && ng < 16) begin
            gcyc[ng] = c;
            for (int i = 0; i < N; i++) if (gnt[i]) gid[ng] = i;
            ng++;
         end
         if (rsp_valid && nr < 16) begin
            rcyc[nr] = c;
            rid[nr] = int'(rsp_id);
            nr++;
         end
         step(1);
      end
      req = '0;
      chk("t2_num_grants", ng, 5);
      chk("t2_num_rsp", nr, 5);
      for (int i = 0; i < 5; i++) begin
         if (i < ng) begin
            chk("t2_gnt_cycle", gcyc[i], exp_c[i]);
            chk("t2_gnt_id", gid[i], exp_id[i]);
         end
         if (i < nr) begin
            chk("t2_rsp_cycle", rcyc[i], exp_c[i] + 2);
            chk("t2_rsp_id", rid[i], exp_id[i]);
         end
      end

      // T3: signed extremes and equality
      set_op(2, 16'h8000, 16'h7FFF);
      run_op(4'b0100, 2, 0, 1, 0, 0);
      set_op(3, 16'h1234, 16'h1234);
      run_op(4'b1000, 3, 0, 0, 1, 0);

      // T5: gt and lt both asserted
      set_op(0, 16'd1, 16'd2);
      force_gt = 1'b1;
      run_op(4'b0001, 0, 0, 0, 0, 1);
      force_gt = 1'b0;

      // T4: consumer stalls; other requesters wait
      set_op(1, 16'd7, 16'd7);
      rsp_ready = 1'b0;
      req = 4'b0010;
      #1;
      chk("t4_gnt", gnt, 4'b0010);
      step(1);
      req = 4'b1111;
      step(1);
      chk("t4_valid", rsp_valid, 1);
      for (int i = 0; i < 5; i++) begin
         step(1);
         chk("t4_hold_valid", rsp_valid, 1);
         chk("t4_hold_rsp", {rsp_id, rsp_gt, rsp_lt, rsp_eq, rsp_err}, {2'd1, 4'b0010});
         chk("t4_no_gnt", gnt, 0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("t4_no_gnt_in_resp", gnt, 0);
      step(1);
      chk("t4_next_gnt", gnt, 4'b0100);
      step(1);
      req = '0;
      step(2);

      // T6: reset during CMP
      set_op(0, 16'd9, 16'd3);
      req = 4'b0001;
      #1;
      chk("t6_gnt", gnt, 4'b0001);
      step(1);
      chk("t6_in_cmp", busy, 1);
      req = 4'b0011;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_busy", busy, 0);
      chk("t6_rst_cmp_a", cmp_a, 0);
      chk("t6_rst_valid", rsp_valid, 0);
      chk("t6_rst_gnt", gnt, 0);
      step(1);
      rst_n = 1'b1;
      #1;
      chk("t6_first_gnt", gnt, 4'b0001);
      chk("t6_no_stale", rsp_valid, 0);
      step(1);
      req = '0;
      chk("t6_cmp_valid", rsp_valid, 0);
      step(1);
      chk("t6_rsp", {rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, rsp_err}, {1'b1, 2'd0, 4'b1000});
      step(3);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
